// File: rtl/bing_clock_divider.sv
// Integer clock divider: q has a period of DIV clk cycles and is driven straight from flops.
// Optional feature macro: DUTY50_EN. When it is defined and DIV is odd, a falling-edge copy of
// the high phase is ORed in, which stretches the high phase to exactly DIV/2 clk periods.
module bing_clock_divider #(
  parameter int unsigned DIV = 3
) (
  input  logic rst,
  input  logic clk,
  output logic q
);

  localparam int unsigned CW   = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int unsigned HIGH = DIV / 2;

  localparam logic [CW-1:0] CntMax  = CW'(DIV - 1);
  localparam logic [CW-1:0] CntHigh = CW'(HIGH);

  if (DIV < 2 || DIV > 65535) begin : g_div_check
    $error("bing_clock_divider: DIV=%0d is outside the legal range 2..65535", DIV);
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_pos_q, q_pos_d;

  // Phase counter wraps at DIV-1; q_pos is high for the first HIGH phases of each period.
  always_comb begin
    cnt_d   = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    q_pos_d = (cnt_d < CntHigh);
  end

  // Rising-edge state with synchronous active-low reset; reset parks the counter on the last
  // phase so the first run edge starts a fresh period with q high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= CntMax;
      q_pos_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      q_pos_q <= q_pos_d;
    end
  end

`ifdef DUTY50_EN
  logic q_neg_q;

  if (DIV % 2 == 1) begin : g_neg
    // Half-cycle delayed copy of q_pos; it follows q_pos low during reset one falling edge later.
    always_ff @(negedge clk) begin
      q_neg_q <= q_pos_q;
    end
  end else begin : g_no_neg
    assign q_neg_q = 1'b0;
  end

  assign q = q_pos_q | q_neg_q;
`else
  assign q = q_pos_q;
`endif

endmodule

// File: tb/tb_bing_clock_divider.sv
// Randomized self-checking bench for bing_clock_divider: several instances with different DIV
// values share one clock and get independent random reset pulses. Expected q comes from the
// number of run edges since the last reset release.
module tb_bing_clock_divider;

  localparam int NI = 5;

  function automatic int unsigned div_of(int g);
    case (g)
      0:       return 2;
      1:       return 3;
      2:       return 4;
      3:       return 5;
      default: return 7;
    endcase
  endfunction

  logic          clk;
  logic [NI-1:0] rst;
  logic [NI-1:0] q_w;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bing_clock_divider #(
      .DIV(div_of(g))
    ) u_dut (
      .rst(rst[g]),
      .clk(clk),
      .q  (q_w[g])
    );
  end

  initial clk = 1'b1;
  always #2 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: run edges since release (0 while in reset), expected flop levels.
  int unsigned k       [NI];
  bit          pos_exp [NI];
  bit          neg_exp [NI];
  int          rem     [NI];
  bit          mid_done;

  function automatic bit high_phase(int unsigned kk, int unsigned d);
    if (kk == 0) return 1'b0;
    return ((kk - 1) % d) < (d / 2);
  endfunction

  initial begin
    rst      = '0;
    mid_done = 1'b0;
    for (int i = 0; i < NI; i++) begin
      k[i]       = 0;
      pos_exp[i] = 1'b0;
      neg_exp[i] = 1'b0;
      rem[i]     = 2;
    end

    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rst[i]) k[i] = 0;
        else         k[i] = k[i] + 1;
        pos_exp[i] = high_phase(k[i], div_of(i));
      end
      #1;
      if (cyc >= 1) begin
        for (int i = 0; i < NI; i++) begin
          check($sformatf("q_rise_div%0d", div_of(i)), {31'd0, q_w[i]},
                {31'd0, pos_exp[i] | neg_exp[i]});
        end
        check("cnt_div3", {30'd0, g_dut[1].u_dut.cnt_q},
              (k[1] == 0) ? 32'd2 : (k[1] - 1) % 3);
      end

      @(negedge clk);
`ifdef DUTY50_EN
      for (int i = 0; i < NI; i++) begin
        if (div_of(i) % 2 == 1) neg_exp[i] = pos_exp[i];
      end
`endif
      #1;
      if (cyc >= 1) begin
        for (int i = 0; i < NI; i++) begin
          check($sformatf("q_fall_div%0d", div_of(i)), {31'd0, q_w[i]},
                {31'd0, pos_exp[i] | neg_exp[i]});
        end
      end

      // Next reset levels, applied well away from the rising edge.
      for (int i = 0; i < NI; i++) begin
        if (rem[i] > 0) begin
          rem[i]--;
        end else if (i == 3 && !mid_done && cyc >= 40 && pos_exp[3]) begin
          rem[i]   = 1;
          mid_done = 1'b1;
        end else if (cyc >= 60 && $urandom_range(0, 24) == 0) begin
          rem[i] = int'($urandom_range(1, 3));
        end
        rst[i] = (rem[i] == 0);
      end
    end

    check("mid_rst_done", {31'd0, mid_done}, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
